evt_stream_compare_mc: RTL and testbench
========================================

Name: evt_stream_compare_mc

Overview:
- Synthesizable, multi-channel event-stream checker: compares each channel's observed DUT beat stream against an expected stream from an event-file reader or pattern ROM.
- Successor to the single-channel, file-bound event recorder. Adds parametrised data width and channel count, expected-data buffering, a bit mask, TLAST checking, a watchdog timeout, and error/beat counters.
- Sits beside the AXI DMA S2MM or MIPI RX output taps, in simulation benches and in on-board self-test builds.

Parameters:
- DATA_WIDTH_G, 64, event word width in bits.
- CH_NB_G, 1, number of independent channels.
- FIFO_DEPTH_G, 16, expected-data buffer depth per channel; power of two, at least 2.
- TIMEOUT_G, 100000, idle cycles in RUN before timeout; 0 disables the watchdog.
- CNT_WIDTH_G, 32, width of the beat and error counters.

Ports:
- clk  in  1  single clock for all logic.
- srst  in  1  synchronous reset, active-high.
- enable_i  in  1  level; high = checking active.
- clear_i  in  1  pulse; clears counters and sticky status.
- mask_i  in  DATA_WIDTH_G  1 = bit compared, 0 = bit ignored.
- dut_valid_i  in  CH_NB_G  qualified DUT beat (valid & ready already ANDed at the tap).
- dut_data_i  in  CH_NB_G*DATA_WIDTH_G  DUT beat data, channel 0 in the LSBs.
- dut_last_i  in  CH_NB_G  DUT TLAST.
- ref_valid_i  in  CH_NB_G  expected-stream valid.
- ref_ready_o  out  CH_NB_G  expected-stream ready.
- ref_data_i  in  CH_NB_G*DATA_WIDTH_G  expected data.
- ref_last_i  in  CH_NB_G  expected TLAST.
- ref_eof_i  in  CH_NB_G  level; expected source exhausted.
- beat_cnt_o  out  CH_NB_G*CNT_WIDTH_G  DUT beats checked.
- err_cnt_o  out  CH_NB_G*CNT_WIDTH_G  errors counted.
- first_err_idx_o  out  CH_NB_G*CNT_WIDTH_G  beat index of the first error.
- stat_error_o  out  1  sticky OR of all channel errors.
- stat_timeout_o  out  1  sticky OR of all channel timeouts.
- stat_end_o  out  1  all channels in DONE or TOUT.

Behaviour:
- Reset and clear_i:
  - srst: all outputs 0, ref_ready_o = 0, FIFOs flushed, every channel to IDLE. srst mid-run discards buffered data with no error flagged.
  - clear_i: zeroes counters, first_err_idx_o and sticky status, and flushes FIFOs. Channel state is kept. If srst and clear_i are both high, srst takes precedence.
- Expected FIFO (per channel):
  - ref_ready_o = registered !full, and only asserted in RUN.
  - A push occurs on ref_valid_i & ref_ready_o and stores {last, data}.
  - Push and pop in the same cycle are legal when the FIFO is not full; the level is unchanged.
  - ref_ready_o deasserts the cycle after the FIFO reaches full.
- State machine (per channel):
  - IDLE -> RUN when enable_i = 1.
  - RUN -> DONE when ref_eof_i = 1, the FIFO is empty, and no DUT beat occurs that cycle.
  - RUN -> TOUT when the watchdog reaches TIMEOUT_G. The watchdog clears on any DUT beat or ref push; TOUT sets the sticky timeout.
  - Any state -> IDLE when enable_i = 0. Counters and status hold in IDLE.
- Compare rules, for each DUT beat in RUN:
  - FIFO non-empty: pop one entry. Mismatch if ((dut ^ ref) & mask_i) != 0 or dut_last != ref_last.
  - FIFO empty and ref_eof_i = 0: starvation error, nothing popped.
  - FIFO empty and ref_eof_i = 1: extra-data error.
  - DUT beat in DONE or TOUT: extra-data error; state unchanged.
  - DUT beats in IDLE are ignored and not counted.
- Counter updates:
  - beat_cnt increments on every checked beat.
  - err_cnt increments once per erroneous beat. Both counters saturate at all-ones; they do not wrap.
  - first_err_idx latches the beat_cnt value (pre-increment) at the first error after reset or clear.
- Latency:
  - Counters and stat_error_o update 1 cycle after the beat.
  - stat_end_o asserts 1 cycle after the last channel leaves RUN.
- Full throughput: one DUT beat per cycle per channel, with no stall path toward the DUT.

Decomposition:
- Package evt_stream_compare_pkg:
  - state enum {IDLE, RUN, DONE, TOUT};
  - error-cause enum {MISMATCH, STARVE, EXTRA};
  - saturating-increment function.
- Sub-module evt_stream_compare_ch: one channel (FIFO, FSM, counters, watchdog).
- Top level: generate-instantiates CH_NB_G channels, slices the buses, ORs the sticky flags and ANDs the end flags.

Test Plan:
- Matched stream, CH_NB_G=2: 256 identical beats per channel, last on beat 255, then ref_eof_i -> beat_cnt=256, err_cnt=0, stat_end_o=1, stat_error_o=0.
- Masked mismatch: beat 10 differs in bit 3 with mask bit 3 = 0 -> err_cnt=0. Same beat with mask bit 3 = 1 -> err_cnt=1, first_err_idx=10, stat_error_o=1 one cycle after the beat.
- TLAST error: ref last on beat 7, DUT last on beat 8 -> err_cnt=2, first_err_idx=7.
- Starvation and extra data:
  - DUT beat with the FIFO empty and eof=0 -> err_cnt=1, nothing popped.
  - 3 DUT beats after DONE -> err_cnt=3, state stays DONE.
- Backpressure and full: hold DUT idle while ref pushes FIFO_DEPTH_G words -> ref_ready_o=0 one cycle after full. One DUT beat -> ready returns next cycle; no data lost.
- Timeout and reset: TIMEOUT_G=50, no traffic for 50 cycles in RUN -> stat_timeout_o=1 and stat_end_o=1. Assert srst mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/evt_stream_compare_pkg.sv
// Shared types and helpers for the multi-channel event-stream checker.
// Channel states, error causes and a width-generic saturating increment.
package evt_stream_compare_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        TOUT
    } state_e;

    typedef enum logic [1:0] {
        MISMATCH,
        STARVE,
        EXTRA
    } err_cause_e;

    localparam int SAT_W = 64;

    // Counters narrower than SAT_W are widened by the caller, then cast back.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] val,
        input int               width
    );
        logic [SAT_W-1:0] max_v;
        max_v = (width >= SAT_W) ? {SAT_W{1'b1}}
                                 : ((SAT_W'(1) << width) - SAT_W'(1));
        return (val >= max_v) ? max_v : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/evt_stream_compare_ch.sv
// One checker channel: expected-data FIFO, state machine, watchdog,
// beat/error counters and sticky status.
module evt_stream_compare_ch #(
    parameter int DATA_WIDTH_G = 64,
    parameter int FIFO_DEPTH_G = 16,
    parameter int TIMEOUT_G    = 100000,
    parameter int CNT_WIDTH_G  = 32
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [DATA_WIDTH_G-1:0] mask_i,
    input  logic                    dut_valid_i,
    input  logic [DATA_WIDTH_G-1:0] dut_data_i,
    input  logic                    dut_last_i,
    input  logic                    ref_valid_i,
    output logic                    ref_ready_o,
    input  logic [DATA_WIDTH_G-1:0] ref_data_i,
    input  logic                    ref_last_i,
    input  logic                    ref_eof_i,
    output logic [CNT_WIDTH_G-1:0]  beat_cnt_o,
    output logic [CNT_WIDTH_G-1:0]  err_cnt_o,
    output logic [CNT_WIDTH_G-1:0]  first_err_idx_o,
    output logic                    error_o,
    output logic                    timeout_o,
    output logic                    end_o
);
    import evt_stream_compare_pkg::*;

    localparam int AW   = $clog2(FIFO_DEPTH_G);
    localparam int LW   = AW + 1;
    localparam int WD_W = (TIMEOUT_G > 1) ? $clog2(TIMEOUT_G + 1) : 1;

    localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH_G);
    localparam logic [WD_W-1:0] WD_MAX   =
        WD_W'((TIMEOUT_G > 0) ? TIMEOUT_G - 1 : 0);

    state_e state_q, state_d;

    logic [DATA_WIDTH_G:0] mem_q [FIFO_DEPTH_G];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  ready_q, ready_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [CNT_WIDTH_G-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH_G-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH_G-1:0] fidx_q, fidx_d;
    logic                   seen_q, seen_d;
    logic                   error_q, error_d;
    logic                   tout_q, tout_d;
    logic                   end_q, end_d;

    logic                  empty, full;
    logic                  push, pop, beat, mis, err, wd_hit;
    logic [DATA_WIDTH_G:0] head;
    err_cause_e            cause;

    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == FULL_LVL);
    assign push  = ref_valid_i & ready_q & ~full;
    assign beat  = dut_valid_i & (state_q != IDLE);
    assign pop   = beat & (state_q == RUN) & ~empty;
    assign head  = mem_q[rd_ptr_q];

    assign mis = (|((dut_data_i ^ head[DATA_WIDTH_G-1:0]) & mask_i))
               | (dut_last_i != head[DATA_WIDTH_G]);

    always_comb begin
        cause = MISMATCH;
        if (state_q != RUN) begin
            cause = EXTRA;
        end else if (empty) begin
            cause = ref_eof_i ? EXTRA : STARVE;
        end
    end

    assign err = beat & ((cause != MISMATCH) | mis);

    assign wd_hit = (TIMEOUT_G != 0) && (wd_q == WD_MAX) && !beat && !push;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable_i) state_d = RUN;
            RUN: begin
                if (wd_hit) begin
                    state_d = TOUT;
                end else if (ref_eof_i && empty && !beat && !push) begin
                    state_d = DONE;
                end
            end
            default: state_d = state_q;
        endcase
        if (!enable_i) state_d = IDLE;
    end

    always_comb begin
        wd_d = '0;
        if (state_q == RUN && state_d == RUN && !beat && !push) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            lvl_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   lvl_d = lvl_q + LW'(1);
                2'b01:   lvl_d = lvl_q - LW'(1);
                default: lvl_d = lvl_q;
            endcase
        end
        // Ready tracks the post-update level so a full FIFO never accepts.
        ready_d = (state_d == RUN) && (lvl_d != FULL_LVL);
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        fidx_d     = fidx_q;
        seen_d     = seen_q;
        error_d    = error_q;
        tout_d     = tout_q;
        if (clear_i) begin
            beat_cnt_d = '0;
            err_cnt_d  = '0;
            fidx_d     = '0;
            seen_d     = 1'b0;
            error_d    = 1'b0;
            tout_d     = 1'b0;
        end else begin
            if (beat) begin
                beat_cnt_d = CNT_WIDTH_G'(sat_inc(SAT_W'(beat_cnt_q),
                                                  CNT_WIDTH_G));
            end
            if (err) begin
                err_cnt_d = CNT_WIDTH_G'(sat_inc(SAT_W'(err_cnt_q),
                                                 CNT_WIDTH_G));
                error_d   = 1'b1;
                if (!seen_q) begin
                    fidx_d = beat_cnt_q;
                    seen_d = 1'b1;
                end
            end
            if (state_q == RUN && state_d == TOUT) tout_d = 1'b1;
        end
        end_d = (state_d == DONE) || (state_d == TOUT);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lvl_q      <= '0;
            ready_q    <= 1'b0;
            wd_q       <= '0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            fidx_q     <= '0;
            seen_q     <= 1'b0;
            error_q    <= 1'b0;
            tout_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            ready_q    <= ready_d;
            wd_q       <= wd_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fidx_q     <= fidx_d;
            seen_q     <= seen_d;
            error_q    <= error_d;
            tout_q     <= tout_d;
            end_q      <= end_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ref_last_i, ref_data_i};
    end

    assign ref_ready_o     = ready_q;
    assign beat_cnt_o      = beat_cnt_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = fidx_q;
    assign error_o         = error_q;
    assign timeout_o       = tout_q;
    assign end_o           = end_q;

endmodule

// File: rtl/evt_stream_compare_mc.sv
// Multi-channel event-stream checker: one evt_stream_compare_ch per channel,
// with per-channel bus slicing and combined sticky/end status.
module evt_stream_compare_mc #(
    parameter int DATA_WIDTH_G = 64,
    parameter int CH_NB_G      = 1,
    parameter int FIFO_DEPTH_G = 16,
    parameter int TIMEOUT_G    = 100000,
    parameter int CNT_WIDTH_G  = 32
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic [DATA_WIDTH_G-1:0]         mask_i,
    input  logic [CH_NB_G-1:0]              dut_valid_i,
    input  logic [CH_NB_G*DATA_WIDTH_G-1:0] dut_data_i,
    input  logic [CH_NB_G-1:0]              dut_last_i,
    input  logic [CH_NB_G-1:0]              ref_valid_i,
    output logic [CH_NB_G-1:0]              ref_ready_o,
    input  logic [CH_NB_G*DATA_WIDTH_G-1:0] ref_data_i,
    input  logic [CH_NB_G-1:0]              ref_last_i,
    input  logic [CH_NB_G-1:0]              ref_eof_i,
    output logic [CH_NB_G*CNT_WIDTH_G-1:0]  beat_cnt_o,
    output logic [CH_NB_G*CNT_WIDTH_G-1:0]  err_cnt_o,
    output logic [CH_NB_G*CNT_WIDTH_G-1:0]  first_err_idx_o,
    output logic                            stat_error_o,
    output logic                            stat_timeout_o,
    output logic                            stat_end_o
);
    import evt_stream_compare_pkg::*;

    localparam int DW = DATA_WIDTH_G;
    localparam int CW = CNT_WIDTH_G;

    logic [CH_NB_G-1:0] err_v;
    logic [CH_NB_G-1:0] tout_v;
    logic [CH_NB_G-1:0] end_v;

    for (genvar g = 0; g < CH_NB_G; g++) begin : g_ch
        evt_stream_compare_ch #(
            .DATA_WIDTH_G (DATA_WIDTH_G),
            .FIFO_DEPTH_G (FIFO_DEPTH_G),
            .TIMEOUT_G    (TIMEOUT_G),
            .CNT_WIDTH_G  (CNT_WIDTH_G)
        ) u_ch (
            .clk             (clk),
            .srst            (srst),
            .enable_i        (enable_i),
            .clear_i         (clear_i),
            .mask_i          (mask_i),
            .dut_valid_i     (dut_valid_i[g]),
            .dut_data_i      (dut_data_i[g*DW +: DW]),
            .dut_last_i      (dut_last_i[g]),
            .ref_valid_i     (ref_valid_i[g]),
            .ref_ready_o     (ref_ready_o[g]),
            .ref_data_i      (ref_data_i[g*DW +: DW]),
            .ref_last_i      (ref_last_i[g]),
            .ref_eof_i       (ref_eof_i[g]),
            .beat_cnt_o      (beat_cnt_o[g*CW +: CW]),
            .err_cnt_o       (err_cnt_o[g*CW +: CW]),
            .first_err_idx_o (first_err_idx_o[g*CW +: CW]),
            .error_o         (err_v[g]),
            .timeout_o       (tout_v[g]),
            .end_o           (end_v[g])
        );
    end

    assign stat_error_o   = |err_v;
    assign stat_timeout_o = |tout_v;
    assign stat_end_o     = &end_v;

endmodule

// File: tb/tb_evt_stream_compare_mc.sv
// Self-checking bench for evt_stream_compare_mc: table-driven compare
// vectors plus directed sequences for stream, full, timeout and reset.
module tb_evt_stream_compare_mc;

    localparam int DW  = 16;
    localparam int CH  = 2;
    localparam int DEP = 4;
    localparam int TO  = 50;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            srst, enable, clear;
    logic [DW-1:0]   mask;
    logic [CH-1:0]   dut_valid, dut_last, ref_valid, ref_last, ref_eof;
    logic [CH-1:0]   ref_ready;
    logic [CH*DW-1:0] dut_data, ref_data;
    logic [CH*CW-1:0] beat_cnt, err_cnt, fidx;
    logic            stat_error, stat_timeout, stat_end;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    evt_stream_compare_mc #(
        .DATA_WIDTH_G (DW),
        .CH_NB_G      (CH),
        .FIFO_DEPTH_G (DEP),
        .TIMEOUT_G    (TO),
        .CNT_WIDTH_G  (CW)
    ) dut (
        .clk             (clk),
        .srst            (srst),
        .enable_i        (enable),
        .clear_i         (clear),
        .mask_i          (mask),
        .dut_valid_i     (dut_valid),
        .dut_data_i      (dut_data),
        .dut_last_i      (dut_last),
        .ref_valid_i     (ref_valid),
        .ref_ready_o     (ref_ready),
        .ref_data_i      (ref_data),
        .ref_last_i      (ref_last),
        .ref_eof_i       (ref_eof),
        .beat_cnt_o      (beat_cnt),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (fidx),
        .stat_error_o    (stat_error),
        .stat_timeout_o  (stat_timeout),
        .stat_end_o      (stat_end)
    );

    typedef struct {
        logic [DW-1:0] rd;
        logic          rl;
        logic [DW-1:0] dd;
        logic          dl;
        logic [DW-1:0] mk;
        logic          clr;
        logic [CW-1:0] e_err;
        logic [CW-1:0] e_fidx;
        logic          e_stat;
    } vec_t;

    vec_t tv [31];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] bc(input int c);
        return 64'(beat_cnt[c*CW +: CW]);
    endfunction

    function automatic logic [63:0] ec(input int c);
        return 64'(err_cnt[c*CW +: CW]);
    endfunction

    function automatic logic [63:0] fc(input int c);
        return 64'(fidx[c*CW +: CW]);
    endfunction

    function automatic logic [DW-1:0] w0(input int k);
        return DW'(k * 5 + 3);
    endfunction

    function automatic logic [DW-1:0] w1(input int k);
        return ~DW'(k);
    endfunction

    task automatic re_enter();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        srst      = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        mask      = '1;
        dut_valid = '0;
        dut_last  = '0;
        dut_data  = '0;
        ref_valid = '0;
        ref_last  = '0;
        ref_data  = '0;
        ref_eof   = '0;

        for (int i = 0; i < 31; i++) begin
            tv[i].rd     = DW'(i * 37 + 5);
            tv[i].rl     = 1'b0;
            tv[i].dd     = DW'(i * 37 + 5);
            tv[i].dl     = 1'b0;
            tv[i].mk     = '1;
            tv[i].clr    = 1'b0;
            tv[i].e_err  = '0;
            tv[i].e_fidx = '0;
            tv[i].e_stat = 1'b0;
        end
        tv[10].dd    = tv[10].rd ^ 16'h0008;
        tv[10].mk    = 16'hFFF7;
        tv[11].clr   = 1'b1;
        tv[21].dd    = tv[21].rd ^ 16'h0008;
        tv[21].e_err = 16'd1; tv[21].e_fidx = 16'd10; tv[21].e_stat = 1'b1;
        tv[22].clr   = 1'b1;
        tv[29].rl    = 1'b1;
        tv[29].e_err = 16'd1; tv[29].e_fidx = 16'd7; tv[29].e_stat = 1'b1;
        tv[30].dl    = 1'b1;
        tv[30].e_err = 16'd2; tv[30].e_fidx = 16'd7; tv[30].e_stat = 1'b1;

        tick();
        tick();
        chk("rst_beat", 64'(beat_cnt), 64'd0);
        chk("rst_err", 64'(err_cnt), 64'd0);
        chk("rst_fidx", 64'(fidx), 64'd0);
        chk("rst_ready", 64'(ref_ready), 64'd0);
        chk("rst_stat", {61'd0, stat_error, stat_timeout, stat_end}, 64'd0);
        srst = 1'b0;

        enable = 1'b1;
        tick();
        chk("run_ready", 64'(ref_ready), 64'd3);

        for (int k = 0; k <= 256; k++) begin
            ref_valid = (k < 256) ? 2'b11 : 2'b00;
            ref_data  = {w1(k), w0(k)};
            ref_last  = (k == 255) ? 2'b11 : 2'b00;
            dut_valid = (k >= 1) ? 2'b11 : 2'b00;
            dut_data  = {w1(k - 1), w0(k - 1)};
            dut_last  = (k == 256) ? 2'b11 : 2'b00;
            tick();
        end
        ref_valid = '0;
        ref_last  = '0;
        dut_valid = '0;
        dut_last  = '0;
        chk("stream_end_early", 64'(stat_end), 64'd0);
        ref_eof = 2'b11;
        tick();
        chk("stream_beat0", bc(0), 64'd256);
        chk("stream_beat1", bc(1), 64'd256);
        chk("stream_err", 64'(err_cnt), 64'd0);
        chk("stream_end", 64'(stat_end), 64'd1);
        chk("stream_error", 64'(stat_error), 64'd0);
        chk("done_ready", 64'(ref_ready), 64'd0);

        dut_valid = 2'b01;
        dut_data  = 32'h0000_5A5A;
        repeat (3) tick();
        dut_valid = '0;
        chk("extra_err0", ec(0), 64'd3);
        chk("extra_err1", ec(1), 64'd0);
        chk("extra_beat0", bc(0), 64'd259);
        chk("extra_fidx0", fc(0), 64'd256);
        chk("extra_error", 64'(stat_error), 64'd1);
        chk("extra_end", 64'(stat_end), 64'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_err0", ec(0), 64'd0);
        chk("clr_beat0", bc(0), 64'd0);
        chk("clr_error", 64'(stat_error), 64'd0);
        chk("clr_end_kept", 64'(stat_end), 64'd1);
        enable  = 1'b0;
        ref_eof = '0;
        tick();
        chk("idle_end", 64'(stat_end), 64'd0);
        enable = 1'b1;
        tick();

        for (int i = 0; i < 31; i++) begin
            if (tv[i].clr) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            ref_valid = 2'b11;
            ref_data  = {tv[i].rd, tv[i].rd};
            ref_last  = {tv[i].rl, tv[i].rl};
            tick();
            ref_valid = '0;
            ref_last  = '0;
            dut_valid = 2'b11;
            dut_data  = {tv[i].rd, tv[i].dd};
            dut_last  = {tv[i].rl, tv[i].dl};
            mask      = tv[i].mk;
            tick();
            dut_valid = '0;
            dut_last  = '0;
            mask      = '1;
            chk($sformatf("vec%0d_err", i), ec(0), 64'(tv[i].e_err));
            chk($sformatf("vec%0d_fidx", i), fc(0), 64'(tv[i].e_fidx));
            chk($sformatf("vec%0d_stat", i), 64'(stat_error),
                64'(tv[i].e_stat));
        end
        chk("vec_beat0", bc(0), 64'd9);
        chk("vec_err1", ec(1), 64'd0);

        clear = 1'b1;
        tick();
        clear     = 1'b0;
        dut_valid = 2'b01;
        dut_data  = 32'h0000_ABCD;
        tick();
        dut_valid = '0;
        chk("starve_err", ec(0), 64'd1);
        chk("starve_beat", bc(0), 64'd1);
        ref_valid = 2'b01;
        ref_data  = 32'h0000_1234;
        tick();
        ref_valid = '0;
        dut_valid = 2'b01;
        dut_data  = 32'h0000_1234;
        tick();
        dut_valid = '0;
        chk("starve_nopop_err", ec(0), 64'd1);
        chk("starve_nopop_beat", bc(0), 64'd2);

        clear = 1'b1;
        tick();
        clear     = 1'b0;
        ref_valid = 2'b01;
        for (int j = 0; j < DEP; j++) begin
            ref_data = 32'(16'h0100 + j);
            tick();
        end
        chk("full_ready0", 64'(ref_ready[0]), 64'd0);
        chk("full_ready1", 64'(ref_ready[1]), 64'd1);
        ref_data = 32'h0000_0199;
        tick();
        chk("full_hold_ready0", 64'(ref_ready[0]), 64'd0);
        ref_valid = '0;
        dut_valid = 2'b01;
        dut_data  = 32'h0000_0100;
        tick();
        chk("full_ret_ready0", 64'(ref_ready[0]), 64'd1);
        for (int j = 1; j < DEP; j++) begin
            dut_data = 32'(16'h0100 + j);
            tick();
        end
        dut_valid = '0;
        chk("full_err0", ec(0), 64'd0);
        chk("full_beat0", bc(0), 64'd4);

        re_enter();
        repeat (TO - 1) tick();
        chk("wd_pre_tout", 64'(stat_timeout), 64'd0);
        chk("wd_pre_end", 64'(stat_end), 64'd0);
        tick();
        chk("wd_tout", 64'(stat_timeout), 64'd1);
        chk("wd_end", 64'(stat_end), 64'd1);

        re_enter();
        ref_valid = 2'b01;
        ref_data  = 32'h0000_0AAA;
        tick();
        ref_data = 32'h0000_0BBB;
        tick();
        ref_valid = '0;
        dut_valid = 2'b01;
        dut_data  = 32'h0000_0AAA;
        tick();
        chk("pre_srst_beat0", bc(0), 64'd5);
        srst     = 1'b1;
        dut_data = 32'h0000_0BBB;
        tick();
        dut_valid = '0;
        chk("srst_beat", 64'(beat_cnt), 64'd0);
        chk("srst_err", 64'(err_cnt), 64'd0);
        chk("srst_fidx", 64'(fidx), 64'd0);
        chk("srst_ready", 64'(ref_ready), 64'd0);
        chk("srst_stat", {61'd0, stat_error, stat_timeout, stat_end}, 64'd0);
        srst = 1'b0;
        tick();
        ref_valid = 2'b01;
        ref_data  = 32'h0000_0CCC;
        tick();
        ref_valid = '0;
        dut_valid = 2'b01;
        dut_data  = 32'h0000_0CCC;
        tick();
        dut_valid = '0;
        chk("post_srst_err0", ec(0), 64'd0);
        chk("post_srst_beat0", bc(0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
